// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the async FIFO write port among NUM_REQ write-domain requesters.
// Grants one requester per burst (packet end or MAX_BURST words), gated combinationally by FULL.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                          W_CLK,
  input  logic                          W_RST,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          FULL,
  output logic                          W_INC,
  output logic [DATA_WIDTH-1:0]         WR_DATA,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy
);

  localparam int GW    = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] BURST_END = CNT_W'(MAX_BURST);
  localparam logic [GW-1:0]    PTR_RST   = GW'(NUM_REQ - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t               r_state,     w_state_nxt;
  logic [GW-1:0]        r_grant_id,  w_grant_id_nxt;
  logic [GW-1:0]        r_last_ptr,  w_last_ptr_nxt;
  logic [CNT_W-1:0]     r_burst_cnt, w_burst_cnt_nxt;

  logic                 w_found;
  logic [GW-1:0]        w_pick;
  logic                 w_sel_valid;
  logic                 w_sel_last;
  logic [DATA_WIDTH-1:0] w_sel_data;
  logic [CNT_W-1:0]     w_cnt_inc;

  // First valid requester searching upward from last_ptr+1, wrapping modulo NUM_REQ.
  always_comb begin : rr_search
    int idx;
    idx     = 0;
    w_found = 1'b0;
    w_pick  = r_last_ptr;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(r_last_ptr) + k) % NUM_REQ;
      if (!w_found && req_valid[GW'(idx)]) begin
        w_found = 1'b1;
        w_pick  = GW'(idx);
      end
    end
  end

  always_comb begin
    w_sel_valid = req_valid[r_grant_id];
    w_sel_last  = req_last[r_grant_id];
    w_sel_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_grant_id == GW'(i)) w_sel_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign w_cnt_inc = r_burst_cnt + CNT_W'(1);

  // NOTE: every variable driven here gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt     = r_state;
    w_grant_id_nxt  = r_grant_id;
    w_last_ptr_nxt  = r_last_ptr;
    w_burst_cnt_nxt = r_burst_cnt;
    req_ready       = '0;
    W_INC           = 1'b0;
    WR_DATA         = '0;

    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_state_nxt     = ST_GRANT;
          w_grant_id_nxt  = w_pick;
          w_burst_cnt_nxt = '0;
        end
      end
      ST_GRANT: begin
        if (!FULL) req_ready = NUM_REQ'(1) << r_grant_id;
        W_INC = w_sel_valid & ~FULL;
        if (W_INC) begin
          WR_DATA         = w_sel_data;
          w_burst_cnt_nxt = w_cnt_inc;
        end
        // Leave on packet end, on the burst cap, or when the grantee abandons the grant.
        if ((W_INC && (w_sel_last || w_cnt_inc == BURST_END)) || !w_sel_valid) begin
          w_state_nxt    = ST_IDLE;
          w_last_ptr_nxt = r_grant_id;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments; reset is asynchronous and active-low.
  always_ff @(posedge W_CLK or negedge W_RST) begin
    if (!W_RST) begin
      r_state     <= ST_IDLE;
      r_grant_id  <= '0;
      r_last_ptr  <= PTR_RST;
      r_burst_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_grant_id  <= w_grant_id_nxt;
      r_last_ptr  <= w_last_ptr_nxt;
      r_burst_cnt <= w_burst_cnt_nxt;
    end
  end

  assign grant_id = r_grant_id;
  assign busy     = (r_state == ST_GRANT);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: per-cycle behavioural model plus directed scenarios
// with hand-computed grant orders, write data and write-cycle spacing.
module tb_fifo_wr_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DW      = 8;
  localparam int MAXB    = 4;

  logic        W_CLK;
  logic        W_RST;
  logic [3:0]  req_valid;
  logic [3:0]  req_last;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        FULL;
  logic        W_INC;
  logic [7:0]  WR_DATA;
  logic [1:0]  grant_id;
  logic        busy;

  fifo_wr_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .DATA_WIDTH(DW),
    .MAX_BURST (MAXB)
  ) dut (
    .W_CLK    (W_CLK),
    .W_RST    (W_RST),
    .req_valid(req_valid),
    .req_last (req_last),
    .req_data (req_data),
    .req_ready(req_ready),
    .FULL     (FULL),
    .W_INC    (W_INC),
    .WR_DATA  (WR_DATA),
    .grant_id (grant_id),
    .busy     (busy)
  );

  initial begin
    W_CLK = 1'b0;
    forever #5 W_CLK = ~W_CLK;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h, required %0h", name, act, exp);
    end
  endtask

  // ---------------- requester sources ----------------
  bit en[4];
  int pkt_len[4];
  int cnt_left[4];
  int pos[4];
  int seq[4];
  bit acc[4];

  function automatic void drive_pins();
    logic [3:0]  v;
    logic [3:0]  l;
    logic [31:0] d;
    v = '0;
    l = '0;
    d = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (en[i] && cnt_left[i] > 0) v = v | (4'(1) << i);
      if (pos[i] == pkt_len[i] - 1) l = l | (4'(1) << i);
      d = d | (32'(8'(i * 32 + seq[i])) << (8 * i));
    end
    req_valid = v;
    req_last  = l;
    req_data  = d;
  endfunction

  function automatic void set_src(input int i, input bit e, input int len, input int cnt);
    en[i]       = e;
    pkt_len[i]  = len;
    cnt_left[i] = cnt;
    pos[i]      = 0;
    seq[i]      = 0;
  endfunction

  function automatic bit any_pending();
    bit p;
    p = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) if (en[i] && cnt_left[i] > 0) p = 1'b1;
    return p;
  endfunction

  task automatic tick();
    @(posedge W_CLK);
    #2;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (acc[i]) begin
        seq[i]++;
        pos[i] = (pos[i] + 1) % pkt_len[i];
        cnt_left[i]--;
      end
    end
    drive_pins();
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while ((busy || any_pending()) && n < budget) begin
      tick();
      n++;
    end
    check({name, " drained within budget"}, 32'((n < budget) ? 1 : 0), 32'(1));
  endtask

  // ---------------- behavioural model ----------------
  bit m_busy;
  int m_gid;
  int m_cnt;
  int m_lptr;

  always @(posedge W_CLK or negedge W_RST) begin : model
    int pick;
    bit v;
    if (!W_RST) begin
      m_busy <= 1'b0;
      m_gid  <= 0;
      m_cnt  <= 0;
      m_lptr <= NUM_REQ - 1;
    end else if (!m_busy) begin
      pick = -1;
      for (int k = 1; k <= NUM_REQ; k++) begin
        int j;
        j = (m_lptr + k) % NUM_REQ;
        if (pick < 0 && bit'(req_valid >> j)) pick = j;
      end
      if (pick >= 0) begin
        m_busy <= 1'b1;
        m_gid  <= pick;
        m_cnt  <= 0;
      end
    end else begin
      v = bit'(req_valid >> m_gid);
      if (v && !FULL) begin
        m_cnt <= m_cnt + 1;
        if (bit'(req_last >> m_gid) || m_cnt + 1 == MAXB) begin
          m_busy <= 1'b0;
          m_lptr <= m_gid;
        end
      end else if (!v) begin
        m_busy <= 1'b0;
        m_lptr <= m_gid;
      end
    end
  end

  // ---------------- per-cycle compare and logging ----------------
  int         cyc = 0;
  bit         prev_busy = 1'b0;
  int         log_grant[$];
  logic [7:0] log_data[$];
  int         log_cyc[$];

  always @(negedge W_CLK) begin : compare
    logic [3:0] e_ready;
    bit         e_inc;
    logic [7:0] e_data;
    cyc++;
    e_inc   = m_busy && bit'(req_valid >> m_gid) && !FULL;
    e_ready = (m_busy && !FULL) ? 4'(1 << m_gid) : 4'b0;
    e_data  = e_inc ? 8'(req_data >> (8 * m_gid)) : 8'h00;
    check($sformatf("c%0d req_ready", cyc), 32'(req_ready), 32'(e_ready));
    check($sformatf("c%0d W_INC", cyc),     32'(W_INC),     32'(e_inc));
    check($sformatf("c%0d WR_DATA", cyc),   32'(WR_DATA),   32'(e_data));
    check($sformatf("c%0d busy", cyc),      32'(busy),      32'(m_busy));
    check($sformatf("c%0d grant_id", cyc),  32'(grant_id),  32'(m_gid));
    if (W_INC) begin
      log_data.push_back(WR_DATA);
      log_cyc.push_back(cyc);
    end
    if (busy && !prev_busy) log_grant.push_back(int'(grant_id));
    prev_busy = busy;
    for (int i = 0; i < NUM_REQ; i++) acc[i] = bit'(req_valid >> i) && bit'(req_ready >> i);
  end

  // ---------------- directed expectations ----------------
  int exp_g[$];
  int exp_d[$];
  int exp_c[$];

  function automatic void clear_logs();
    log_grant.delete();
    log_data.delete();
    log_cyc.delete();
  endfunction

  task automatic check_logs(input string tag);
    int n;
    check({tag, " grant count"}, 32'(log_grant.size()), 32'(exp_g.size()));
    n = (log_grant.size() < exp_g.size()) ? log_grant.size() : exp_g.size();
    for (int k = 0; k < n; k++) check($sformatf("%s grant%0d", tag, k), 32'(log_grant[k]), 32'(exp_g[k]));
    check({tag, " write count"}, 32'(log_data.size()), 32'(exp_d.size()));
    n = (log_data.size() < exp_d.size()) ? log_data.size() : exp_d.size();
    for (int k = 0; k < n; k++) check($sformatf("%s data%0d", tag, k), 32'(log_data[k]), 32'(exp_d[k]));
    if (exp_c.size() > 0) begin
      n = (log_cyc.size() < exp_c.size()) ? log_cyc.size() : exp_c.size();
      for (int k = 0; k < n; k++)
        check($sformatf("%s write%0d cycle", tag, k), 32'(log_cyc[k] - log_cyc[0]), 32'(exp_c[k]));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    // Reset defaults with every requester valid.
    W_RST = 1'b0;
    FULL  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) set_src(i, 1'b1, 1, 100);
    drive_pins();
    tick();
    tick();
    check("reset req_ready", 32'(req_ready), 32'(0));
    check("reset W_INC",     32'(W_INC),     32'(0));
    check("reset WR_DATA",   32'(WR_DATA),   32'(0));
    check("reset busy",      32'(busy),      32'(0));
    check("reset grant_id",  32'(grant_id),  32'(0));

    // Round-robin with single-word packets; requester 0 has two packets.
    for (int i = 0; i < NUM_REQ; i++) set_src(i, 1'b1, 1, (i == 0) ? 2 : 1);
    clear_logs();
    drive_pins();
    W_RST = 1'b1;
    tick();
    #1;
    check("first grant busy", 32'(busy),     32'(1));
    check("first grant id",   32'(grant_id), 32'(0));
    wait_idle("rr", 40);
    exp_g = '{0, 1, 2, 3, 0};
    exp_d = '{'h00, 'h20, 'h40, 'h60, 'h01};
    exp_c = '{0, 2, 4, 6, 8};
    check_logs("rr");

    // Burst cap: requester 2 alone, one 10-word packet.
    for (int i = 0; i < NUM_REQ; i++) set_src(i, 1'b0, 1, 0);
    set_src(2, 1'b1, 10, 10);
    clear_logs();
    drive_pins();
    wait_idle("cap", 60);
    exp_g = '{2, 2, 2};
    exp_d = '{'h40, 'h41, 'h42, 'h43, 'h44, 'h45, 'h46, 'h47, 'h48, 'h49};
    exp_c = '{0, 1, 2, 3, 5, 6, 7, 8, 10, 11};
    check_logs("cap");

    // FULL for 5 cycles after word 2 of a burst from requester 0.
    set_src(2, 1'b0, 1, 0);
    set_src(0, 1'b1, 8, 6);
    clear_logs();
    drive_pins();
    tick();
    tick();
    tick();
    FULL = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      check($sformatf("full%0d W_INC", k),     32'(W_INC),     32'(0));
      check($sformatf("full%0d req_ready", k), 32'(req_ready), 32'(0));
      check($sformatf("full%0d busy", k),      32'(busy),      32'(1));
      check($sformatf("full%0d grant_id", k),  32'(grant_id),  32'(0));
      tick();
    end
    FULL = 1'b0;
    wait_idle("full", 40);
    exp_g = '{0, 0};
    exp_d = '{'h00, 'h01, 'h02, 'h03, 'h04, 'h05};
    exp_c = '{0, 1, 7, 8, 10, 11};
    check_logs("full");

    // Abandon: requester 1 drops valid after one word while 0 and 3 wait.
    set_src(0, 1'b0, 1, 0);
    set_src(1, 1'b1, 8, 8);
    clear_logs();
    drive_pins();
    tick();
    set_src(0, 1'b1, 1, 1);
    set_src(3, 1'b1, 1, 1);
    drive_pins();
    tick();
    en[1] = 1'b0;
    drive_pins();
    #1;
    check("abandon still granted", 32'(busy), 32'(1));
    tick();
    #1;
    check("abandon idle busy", 32'(busy),     32'(0));
    check("abandon last id",   32'(grant_id), 32'(1));
    wait_idle("abandon", 40);
    exp_g = '{1, 3, 0};
    exp_d = '{'h20, 'h60, 'h00};
    exp_c.delete();
    check_logs("abandon");

    // Async reset pulse during word 2 of a 4-word burst from requester 2.
    set_src(1, 1'b0, 1, 0);
    set_src(2, 1'b1, 4, 4);
    clear_logs();
    drive_pins();
    tick();
    set_src(0, 1'b1, 1, 1);
    set_src(3, 1'b1, 1, 1);
    drive_pins();
    tick();
    W_RST = 1'b0;
    #1;
    check("async rst req_ready", 32'(req_ready), 32'(0));
    check("async rst W_INC",     32'(W_INC),     32'(0));
    check("async rst WR_DATA",   32'(WR_DATA),   32'(0));
    check("async rst busy",      32'(busy),      32'(0));
    check("async rst grant_id",  32'(grant_id),  32'(0));
    #1;
    W_RST = 1'b1;
    wait_idle("async", 60);
    exp_g = '{2, 0, 2, 3};
    exp_d = '{'h40, 'h00, 'h41, 'h42, 'h43, 'h60};
    check_logs("async");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
